pool_map_collector: RTL and testbench

- Sink side of the pooling-layer row interface. Captures pooled rows of OUTPUT_SIZE words, tagged with feature index and input-row index, into a full pooled-map buffer.
- Once every (feature, pooled row) slot is filled, streams the map out one word at a time over a valid/ready handshake to the next layer.
- Sits between the pooling layer and the fully-connected stage.

---
 rtl/pooling_pkg.sv | 26 ++
 rtl/pool_map_rd_cnt.sv | 68 ++++++
 rtl/pool_map_collector.sv | 161 ++++++++++++++++
 tb/tb_pool_map_collector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared types and width helpers for the pooling-layer map collector.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  // Number of bits needed to hold the value itself (so 4 -> 3, 6 -> 3, 3 -> 2).
  function automatic int logb2(input int value);
    int n;
    n = 0;
    for (int v = value; v > 0; v = v >> 1) n++;
    return n;
  endfunction

  // Index widths for the default 6x6 input / 2x2 pool / 4-feature layer.
  localparam int ROW_WIDTH      = logb2(6);
  localparam int FEATURE_WIDTH  = logb2(4);
  localparam int POOL_IDX_WIDTH = logb2(3);

endpackage

// File: rtl/pool_map_rd_cnt.sv
// Drain-side position counter: col fastest, then row, then feature.
module pool_map_rd_cnt
  import pooling_pkg::*;
#(
  parameter int FEATURES = 4,
  parameter int SIZE     = 3,
  parameter int FW       = FEATURE_WIDTH,
  parameter int PW       = POOL_IDX_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance_i,
  input  logic          clear_i,
  output logic [FW-1:0] feat_o,
  output logic [PW-1:0] row_o,
  output logic [PW-1:0] col_o,
  output logic          last_o
);

  logic [FW-1:0] feat_q, feat_d;
  logic [PW-1:0] row_q, row_d, col_q, col_d;
  logic          col_last, row_last, feat_last;

  assign col_last  = (int'(col_q)  == SIZE - 1);
  assign row_last  = (int'(row_q)  == SIZE - 1);
  assign feat_last = (int'(feat_q) == FEATURES - 1);

  always_comb begin
    feat_d = feat_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clear_i) begin
      feat_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (advance_i) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          feat_d = feat_last ? '0 : feat_q + FW'(1);
        end else begin
          row_d = row_q + PW'(1);
        end
      end else begin
        col_d = col_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      feat_q <= feat_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign feat_o = feat_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_last && row_last && feat_last;

endmodule

// File: rtl/pool_map_collector.sv
// Collects pooled rows into a full feature-map buffer, then streams it out
// word by word over valid/ready once every (feature, pooled row) slot is filled.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pool_map_collector
  import pooling_pkg::*;
#(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int OUTPUT_SIZE   = 3,
  parameter int TOTAL_FEATURE = 4,
  localparam int DW = `DATA_WIDTH,
  localparam int FW = logb2(TOTAL_FEATURE),
  localparam int RW = logb2(INPUT_SIZE),
  localparam int PW = logb2(OUTPUT_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [FW-1:0]             in_feature_idx,
  input  logic [RW-1:0]             in_feature_row,
  input  logic [OUTPUT_SIZE*DW-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic [FW-1:0]             out_feature,
  output logic [PW-1:0]             out_row,
  output logic [PW-1:0]             out_col,
  output logic                      out_last,
  output logic                      map_done,
  output logic                      err_overrun,
  output logic                      err_range,
  input  logic                      err_clr
);

  localparam int NSLOT    = TOTAL_FEATURE * OUTPUT_SIZE;
  localparam int ROW_BITS = OUTPUT_SIZE * DW;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] mem_q [NSLOT];
  logic [NSLOT-1:0]    bmp_q, bmp_d, wr_mask;
  logic                in_range, wr_en, cnt_adv, cnt_clr;
  logic                done_q, done_d;
  logic                err_rng_q, err_rng_d, err_ovr_q, err_ovr_d;
  int                  wr_slot, rd_slot;
  logic [FW-1:0]       rd_feat;
  logic [PW-1:0]       rd_row, rd_col;
  logic                rd_last;
  logic [ROW_BITS-1:0] rd_line;
  logic [DW-1:0]       rd_word;

  // Slot = feature * OUTPUT_SIZE + pooled row; out-of-range rows yield an empty mask.
  always_comb begin
    in_range = (int'(in_feature_idx) < TOTAL_FEATURE) &&
               ((int'(in_feature_row) / KERNEL_SIZE) < OUTPUT_SIZE);
    wr_slot  = int'(in_feature_idx) * OUTPUT_SIZE + int'(in_feature_row) / KERNEL_SIZE;
    for (int i = 0; i < NSLOT; i++) wr_mask[i] = in_range && (wr_slot == i);
  end

  always_comb begin
    state_d = state_q;
    bmp_d   = bmp_q;
    wr_en   = 1'b0;
    cnt_adv = 1'b0;
    cnt_clr = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_valid && in_range) begin
          wr_en = 1'b1;
          bmp_d = bmp_q | wr_mask;
          if (&bmp_d) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_last) begin
            cnt_clr = 1'b1;
            done_d  = 1'b1;
            bmp_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // A new error event on the same cycle as err_clr must survive the clear.
  always_comb begin
    err_rng_d = err_rng_q;
    err_ovr_d = err_ovr_q;
    if (err_clr) begin
      err_rng_d = 1'b0;
      err_ovr_d = 1'b0;
    end
    if (in_valid && !in_range)           err_rng_d = 1'b1;
    if (in_valid && state_q == S_DRAIN)  err_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      bmp_q     <= '0;
      done_q    <= 1'b0;
      err_rng_q <= 1'b0;
      err_ovr_q <= 1'b0;
      for (int i = 0; i < NSLOT; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bmp_q     <= bmp_d;
      done_q    <= done_d;
      err_rng_q <= err_rng_d;
      err_ovr_q <= err_ovr_d;
      for (int i = 0; i < NSLOT; i++)
        if (wr_en && wr_mask[i]) mem_q[i] <= in_data;
    end
  end

  pool_map_rd_cnt #(
    .FEATURES (TOTAL_FEATURE),
    .SIZE     (OUTPUT_SIZE),
    .FW       (FW),
    .PW       (PW)
  ) u_rd_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (cnt_adv),
    .clear_i   (cnt_clr),
    .feat_o    (rd_feat),
    .row_o     (rd_row),
    .col_o     (rd_col),
    .last_o    (rd_last)
  );

  // Word 0 of a stored row sits in the MSBs.
  always_comb begin
    rd_slot = int'(rd_feat) * OUTPUT_SIZE + int'(rd_row);
    rd_line = '0;
    for (int i = 0; i < NSLOT; i++)
      if (rd_slot == i) rd_line = mem_q[i];
    rd_word = '0;
    for (int c = 0; c < OUTPUT_SIZE; c++)
      if (int'(rd_col) == c) rd_word = rd_line[(OUTPUT_SIZE-1-c)*DW +: DW];
  end

  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? rd_word : '0;
  assign out_feature = out_valid ? rd_feat : '0;
  assign out_row     = out_valid ? rd_row  : '0;
  assign out_col     = out_valid ? rd_col  : '0;
  assign out_last    = out_valid && rd_last;
  assign map_done    = done_q;
  assign err_range   = err_rng_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_pool_map_collector.sv
// Scoreboard bench for pool_map_collector: stimulus fills a reference map,
// a monitor pops expected words as the DUT hands them over.
module tb_pool_map_collector;
  import pooling_pkg::*;

  localparam int DW = 32;
  localparam int OS = 3;
  localparam int TF = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic [FEATURE_WIDTH-1:0]  in_feature_idx = '0;
  logic [ROW_WIDTH-1:0]      in_feature_row = '0;
  logic [OS*DW-1:0]          in_data = '0;
  logic                      out_ready = 1'b0;
  logic                      err_clr = 1'b0;
  logic                      out_valid, out_last, map_done, err_overrun, err_range;
  logic [DW-1:0]             out_data;
  logic [FEATURE_WIDTH-1:0]  out_feature;
  logic [POOL_IDX_WIDTH-1:0] out_row, out_col;

  always #5 clk = ~clk;

  pool_map_collector #(
    .INPUT_SIZE(6), .KERNEL_SIZE(2), .OUTPUT_SIZE(OS), .TOTAL_FEATURE(TF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_feature_idx(in_feature_idx),
    .in_feature_row(in_feature_row), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_feature(out_feature),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .map_done(map_done),
    .err_overrun(err_overrun), .err_range(err_range), .err_clr(err_clr)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            f, r, c;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [TF][OS][OS];
  bit            filled [TF][OS];
  bit            draining, exp_rng, exp_ovr, done_exp;
  int            n_chk, n_fail, n_popped;
  int            rdy_mode, stall_at = -1, stall_left;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: a slot array; when every slot is full the whole map
  // is queued in feature/row/col order.
  task automatic send_row(input int f, input int row, input logic [DW-1:0] w0,
                          input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                          input bit clr = 1'b0);
    bit rng, ovr, all;
    int pr;
    pr  = row / 2;
    rng = (f >= TF) || (pr >= OS);
    ovr = draining;
    in_valid       = 1'b1;
    in_feature_idx = f[FEATURE_WIDTH-1:0];
    in_feature_row = row[ROW_WIDTH-1:0];
    in_data        = {w0, w1, w2};
    err_clr        = clr;
    if (clr && !rng) exp_rng = 1'b0;
    if (clr && !ovr) exp_ovr = 1'b0;
    if (rng) exp_rng = 1'b1;
    if (ovr) exp_ovr = 1'b1;
    if (!rng && !ovr) begin
      mdl_mem[f][pr][0] = w0;
      mdl_mem[f][pr][1] = w1;
      mdl_mem[f][pr][2] = w2;
      filled[f][pr] = 1'b1;
      all = 1'b1;
      for (int i = 0; i < TF; i++) for (int j = 0; j < OS; j++) all &= filled[i][j];
      if (all) begin
        for (int i = 0; i < TF; i++)
          for (int j = 0; j < OS; j++) begin
            filled[i][j] = 1'b0;
            for (int k = 0; k < OS; k++)
              exp_q.push_back('{mdl_mem[i][j][k], i, j, k, (i == TF-1 && j == OS-1 && k == OS-1)});
          end
        n_popped = 0;
        draining = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    chk("err_range", err_range, exp_rng);
    chk("err_overrun", err_overrun, exp_ovr);
    if (!ovr) chk("out_valid_after_row", out_valid, draining);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    exp_rng = 1'b0;
    exp_ovr = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_range_clr", err_range, 0);
    chk("err_overrun_clr", err_overrun, 0);
  endtask

  function automatic logic [DW-1:0] pat(input int base, input int f, input int r, input int c);
    return DW'(base + f*100 + r*10 + c);
  endfunction

  task automatic fill_pattern(input int base, input bit desc, input bit dup);
    int f, r;
    for (int a = 0; a < TF; a++)
      for (int b = 0; b < OS; b++) begin
        f = desc ? TF-1-a : a;
        r = desc ? OS-1-b : b;
        if (dup && f == 1 && r == OS-1) send_row(2, 3, DW'(999), DW'(999), DW'(999));
        send_row(f, 2*r+1, pat(base,f,r,0), pat(base,f,r,1), pat(base,f,r,2));
      end
  endtask

  task automatic fill_random();
    int slots[TF*OS];
    int j, t;
    for (int i = 0; i < TF*OS; i++) slots[i] = i;
    for (int i = TF*OS-1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = slots[i]; slots[i] = slots[j]; slots[j] = t;
    end
    for (int i = 0; i < TF*OS; i++)
      send_row(slots[i] / OS, 2*(slots[i] % OS) + $urandom_range(1, 0),
               $urandom, $urandom, $urandom);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (draining && k < 3000) begin @(negedge clk); k++; end
    @(negedge clk); @(negedge clk);
    chk("drain_complete", out_valid, 0);
    chk("words_left", exp_q.size(), 0);
    exp_q.delete();
    draining = 1'b0;
  endtask

  task automatic wait_pop(input int n);
    int k;
    k = 0;
    while (n_popped < n && k < 2000) begin @(negedge clk); k++; end
    chk("drain_active", out_valid, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_map_done", map_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    exp_q.delete();
    draining = 1'b0;
    exp_rng  = 1'b0;
    exp_ovr  = 1'b0;
    for (int i = 0; i < TF; i++) for (int j = 0; j < OS; j++) filled[i][j] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  // Ready driver: always-on, toggling or random, with an optional stall.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && n_popped == stall_at) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ~out_ready;
          default: out_ready = 1'($urandom_range(1, 0));
        endcase
      end
    end
  end

  // Monitor: pops on each handshake, checks hold-while-stalled and map_done.
  initial begin
    exp_t          e;
    bit            prev_stall;
    logic [DW-1:0] p_data;
    logic [FEATURE_WIDTH-1:0] p_f;
    logic [POOL_IDX_WIDTH-1:0] p_r, p_c;
    logic          p_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        done_exp   = 1'b0;
        continue;
      end
      chk("map_done", map_done, done_exp);
      done_exp = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_feature", out_feature, p_f);
        chk("stall_row", out_row, p_r);
        chk("stall_col", out_col, p_c);
        chk("stall_last", out_last, p_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_feature", out_feature, e.f);
          chk("out_row", out_row, e.r);
          chk("out_col", out_col, e.c);
          chk("out_last", out_last, e.last);
          if (e.last) begin
            done_exp = 1'b1;
            draining = 1'b0;
          end
        end
        n_popped++;
      end
      prev_stall = out_valid && !out_ready;
      p_data = out_data; p_f = out_feature; p_r = out_row; p_c = out_col; p_last = out_last;
    end
  end

  initial begin
    rdy_mode = 0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_feature", out_feature, 0);
    chk("reset_out_row", out_row, 0);
    chk("reset_out_col", out_col, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_map_done", map_done, 0);
    chk("reset_err_range", err_range, 0);
    chk("reset_err_overrun", err_overrun, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ordered fill, free-flowing drain
    fill_pattern(0, 1'b0, 1'b0);
    wait_drain();

    // Toggling ready plus a 5-cycle stall on word 17
    rdy_mode = 1; stall_at = 17; stall_left = 5;
    fill_pattern(1000, 1'b0, 1'b0);
    wait_drain();
    stall_at = -1;

    // Descending order with a rewrite of feature 2, row 3
    rdy_mode = 2;
    fill_pattern(2000, 1'b1, 1'b1);
    wait_drain();

    // Range errors, clear, and set-wins-over-clear
    rdy_mode = 0;
    send_row(4, 1, 32'd7, 32'd7, 32'd7);
    send_row(0, 6, 32'd8, 32'd8, 32'd8);
    clear_err();
    send_row(5, 3, 32'd9, 32'd9, 32'd9, 1'b1);
    clear_err();

    // Overrun mid-drain must not disturb the stream
    rdy_mode = 2;
    fill_random();
    wait_pop(3);
    send_row(1, 1, $urandom, $urandom, $urandom);
    wait_drain();
    clear_err();

    // Reset mid-drain, then a fresh map starting at (0,0,0)
    rdy_mode = 1;
    fill_random();
    wait_pop(10);
    do_reset();
    rdy_mode = 0;
    fill_pattern(0, 1'b0, 1'b0);
    wait_drain();

    rdy_mode = 2;
    fill_random();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
